// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Result encoding is {gt, eq, lt}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One-bit magnitude cell; swap inverts the sense for a two's-complement
// sign bit, where a set bit means the smaller value.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic swap,
    output logic gt_bit,
    output logic lt_bit
);

    logic g;
    logic l;

    // Raw unsigned bit order, optionally swapped for the sign position
    always_comb begin
        g      = a_bit & ~b_bit;
        l      = ~a_bit & b_bit;
        gt_bit = swap ? l : g;
        lt_bit = swap ? g : l;
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake,
// optional early exit and two's-complement mode.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode_signed,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic                     gt,
    output logic                     eq,
    output logic                     lt,
    output logic [cnt_w(WIDTH)-1:0]  bits_examined
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             diff_q, diff_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       res_q, res_d;

    logic             swap;
    logic             gt_bit;
    logic             lt_bit;
    logic             bit_diff;
    logic [2:0]       bit_res;
    logic             last;

    assign swap     = mode_q && (cnt_q == '0);
    assign bit_diff = gt_bit | lt_bit;
    assign bit_res  = {gt_bit, 1'b0, lt_bit};
    assign last     = (cnt_q == CW'(WIDTH - 1));

    cmp_bit_cell u_cell (
        .a_bit  (a_q[WIDTH-1]),
        .b_bit  (b_q[WIDTH-1]),
        .swap   (swap),
        .gt_bit (gt_bit),
        .lt_bit (lt_bit)
    );

    // Next-state: capture on accept, shift and resolve while comparing
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        pend_d  = pend_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode_signed;
                    cnt_d   = '0;
                    diff_d  = 1'b0;
                    pend_d  = RES_NONE;
                    res_d   = RES_NONE;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                a_d   = a_q << 1;
                b_d   = b_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (!diff_q && bit_diff) begin
                    diff_d = 1'b1;
                    pend_d = bit_res;
                end
                if (EARLY_EXIT && !diff_q && bit_diff) begin
                    res_d   = bit_res;
                    state_d = DONE;
                end else if (last) begin
                    state_d = DONE;
                    if (diff_q)
                        res_d = pend_q;
                    else if (bit_diff)
                        res_d = bit_res;
                    else
                        res_d = RES_EQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= 1'b0;
            pend_q  <= RES_NONE;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            pend_q  <= pend_d;
            res_q   <= res_d;
        end
    end

    assign busy          = (state_q == COMPARE);
    assign done          = (state_q == DONE);
    assign gt            = res_q[2];
    assign eq            = res_q[1];
    assign lt            = res_q[0];
    assign bits_examined = cnt_q;

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
Parametrised, bit-serial magnitude comparator. It is the sequential successor to the team's combinational SOP and comparator blocks. Operands of WIDTH bits are captured on a start strobe and compared MSB-first, one bit per clock, with optional early exit and a signed (two's-complement) mode. It returns one-hot gt/eq/lt flags with a done pulse, and is used wherever an area-cheap comparator with a start/done handshake is needed.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
EARLY_EXIT, 1, 1 = stop at the first differing bit; 0 = always examine all WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only when the block is accepting
mode_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while in COMPARE
done  output  1  one-cycle pulse; result valid
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B
bits_examined  output  $clog2(WIDTH+1)  number of bit positions examined for the last result

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - state <= IDLE; busy=0, done=0, gt=eq=lt=0, bits_examined=0.
  - The shift registers and counter are cleared.
  - Reset overrides start and aborts any comparison in progress. No done is produced for an aborted operation.
- States:
  - IDLE: accepting. start=1 captures a, b and mode_signed into shift registers, sets counter=0 and moves to COMPARE.
  - COMPARE: busy=1. Each edge examines the current MSB pair (a_s, b_s) and increments the counter.
    - On a difference: gt = a_s & ~b_s, lt = ~a_s & b_s. If signed mode is set and this is the first examined bit (counter==0, the sign bit), gt and lt are swapped.
    - With EARLY_EXIT=1, the first difference latches the result and moves to DONE.
    - With EARLY_EXIT=0, the first difference is latched and later bits are ignored.
    - When the last bit is examined (counter==WIDTH-1): if no difference has been seen, eq=1; state moves to DONE.
    - The shift registers shift left by 1 each COMPARE edge.
  - DONE: done=1 for exactly one cycle; busy=0. Unconditionally moves to IDLE. DONE is also accepting: start=1 here captures new operands and moves directly to COMPARE, allowing back-to-back operations.
- Outputs:
  - gt, eq and lt are exactly one-hot from the first done onward.
  - They and bits_examined are held stable from DONE until the next accepted start.
  - They clear to 0 on the edge that accepts a new start, and remain 0 while busy.
- Latency:
  - Counting from the edge that accepts start, done is high in the cycle after edge N, where N = bits_examined.
  - With EARLY_EXIT=1, N = 1 + index (from MSB) of the first differing bit, or WIDTH if A == B.
  - With EARLY_EXIT=0, N = WIDTH always.
- start while in COMPARE is ignored. The operands and mode in flight are unaffected.
- Changes on a, b and mode_signed after capture have no effect.
- Counter width is $clog2(WIDTH+1). It never wraps, because the maximum value is WIDTH.

Decomposition:
- Package cmp_pkg:
  - state enum {IDLE, COMPARE, DONE};
  - result-encoding localparams RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001;
  - function cnt_w(width) returning $clog2(width+1).
- One combinational sub-module, cmp_bit_cell (inputs a_bit, b_bit, swap; outputs gt_bit, lt_bit), instantiated once on the MSB pair. The top level holds the FSM, the shift registers and the counter.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, unsigned, a=8'h5A, b=8'h5A -> eq=1, gt=lt=0, bits_examined=8, done in the cycle after edge 8.
2. unsigned, a=8'h80, b=8'h7F -> gt=1, bits_examined=1, done in the cycle after edge 1; flags held through 3 further idle cycles.
3. signed, a=8'h80, b=8'h7F -> lt=1 (-128 < 127), bits_examined=1. Also signed a=8'hFF, b=8'hFE -> gt=1 (-1 > -2), bits_examined=8.
4. EARLY_EXIT=0, unsigned, a=8'h12, b=8'h92 -> gt=0, lt=1, bits_examined=8; a start pulse with a=8'hFF mid-run is ignored and the result is unchanged.
5. rst=1 on the 3rd COMPARE edge of a=8'h01, b=8'h02 -> next cycle busy=0, done=0, all flags 0; a new start with a=8'h03, b=8'h03 then yields eq=1 after 8 edges.
6. Back-to-back: start held high in the DONE cycle of a=8'h40, b=8'h20 (gt) with new a=8'h20, b=8'h40 -> the second operation proceeds with no IDLE cycle, giving lt=1, bits_examined=2; exactly two done pulses in total.
